// File: rtl/sync_fifo_out.sv
// Read side of a synchronous FIFO: owns the read pointer and a one-word
// first-word-fall-through output register fed from an asynchronous memory read port.
module sync_fifo_out #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  fifo_read_en_h_i,
  output logic [DATA_WIDTH-1:0] fifo_read_data_o,
  output logic                  fifo_empty_h_o,
  output logic [ADDR_WIDTH+1:0] fifo_level_o,
  output logic                  fifo_underflow_h_o,
  output logic                  fifo_ptr_err_h_o,
  input  logic [ADDR_WIDTH:0]   write_addr_i,
  output logic [ADDR_WIDTH:0]   read_addr_o,
  input  logic [DATA_WIDTH-1:0] read_data_i
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int LVL_W = ADDR_WIDTH + 2;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
  logic                  out_valid_reg, out_valid_next;
  logic                  underflow_reg, underflow_next;
  logic                  ptr_err_reg, ptr_err_next;

  logic [PTR_W-1:0] mem_count;
  logic             mem_empty;
  logic             pop;
  logic             load;
  logic             ptr_gap;

  // Words sitting in memory; the wrap bit makes the subtraction unambiguous.
  assign mem_count = write_addr_i - rd_ptr_reg;
  assign mem_empty = (write_addr_i == rd_ptr_reg);
  assign pop       = fifo_read_en_h_i & out_valid_reg;
  assign load      = ~mem_empty & (~out_valid_reg | pop);
  assign ptr_gap   = ({1'b0, mem_count} > LVL_W'(DEPTH));

  always_comb begin
    rd_ptr_next    = rd_ptr_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    if (load) begin
      out_data_next  = read_data_i;
      out_valid_next = 1'b1;
      rd_ptr_next    = rd_ptr_reg + PTR_W'(1);
    end else if (pop) begin
      out_valid_next = 1'b0;
    end
    underflow_next = underflow_reg | (fifo_read_en_h_i & ~out_valid_reg);
    ptr_err_next   = ptr_err_reg | ptr_gap;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rd_ptr_reg    <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      underflow_reg <= 1'b0;
      ptr_err_reg   <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      underflow_reg <= underflow_next;
      ptr_err_reg   <= ptr_err_next;
    end
  end

  assign read_addr_o        = rd_ptr_reg;
  assign fifo_read_data_o   = out_data_reg;
  assign fifo_empty_h_o     = ~out_valid_reg;
  assign fifo_level_o       = {1'b0, mem_count} + LVL_W'(out_valid_reg);
  assign fifo_underflow_h_o = underflow_reg;
  assign fifo_ptr_err_h_o   = ptr_err_reg;

endmodule

// File: tb/tb_sync_fifo_out.sv
// Randomized bench for sync_fifo_out against a queue-based model of the
// producer memory contents plus the head word.
module tb_sync_fifo_out;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk_i = 1'b0;
  logic          resetn_i;
  logic          fifo_read_en_h_i;
  logic [DW-1:0] fifo_read_data_o;
  logic          fifo_empty_h_o;
  logic [AW+1:0] fifo_level_o;
  logic          fifo_underflow_h_o;
  logic          fifo_ptr_err_h_o;
  logic [AW:0]   write_addr_i;
  logic [AW:0]   read_addr_o;
  logic [DW-1:0] read_data_i;

  logic [DW-1:0] tb_mem [DEPTH];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] pend[$];
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [AW:0]   m_rd;
  logic          m_uf;
  logic          m_err;

  sync_fifo_out #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i              (clk_i),
    .resetn_i           (resetn_i),
    .fifo_read_en_h_i   (fifo_read_en_h_i),
    .fifo_read_data_o   (fifo_read_data_o),
    .fifo_empty_h_o     (fifo_empty_h_o),
    .fifo_level_o       (fifo_level_o),
    .fifo_underflow_h_o (fifo_underflow_h_o),
    .fifo_ptr_err_h_o   (fifo_ptr_err_h_o),
    .write_addr_i       (write_addr_i),
    .read_addr_o        (read_addr_o),
    .read_data_i        (read_data_i)
  );

  always #5 clk_i = ~clk_i;

  assign read_data_i = tb_mem[read_addr_o[AW-1:0]];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_val("empty",     32'(fifo_empty_h_o),     32'(!m_valid));
    check_val("data",      32'(fifo_read_data_o),   32'(m_data));
    check_val("rd_addr",   32'(read_addr_o),        32'(m_rd));
    check_val("level",     32'(fifo_level_o),       32'(pend.size()) + 32'(m_valid));
    check_val("underflow", 32'(fifo_underflow_h_o), 32'(m_uf));
    check_val("ptr_err",   32'(fifo_ptr_err_h_o),   32'(m_err));
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    if (pend.size() < DEPTH) begin
      tb_mem[write_addr_i[AW-1:0]] = d;
      write_addr_i = write_addr_i + 1'b1;
      pend.push_back(d);
    end
  endtask

  // One clock with the given pop request; model updates from pre-edge state.
  task automatic cycle(input logic en);
    logic pop;
    fifo_read_en_h_i = en;
    @(posedge clk_i);
    pop = en && m_valid;
    if (en && !m_valid) m_uf = 1'b1;
    if (pend.size() > 0 && (!m_valid || pop)) begin
      m_data  = pend.pop_front();
      m_valid = 1'b1;
      m_rd    = m_rd + 1'b1;
    end else if (pop) begin
      m_valid = 1'b0;
    end
    #1;
    $display("cycle en=%0b rd=%0d lvl=%0d data=%h empty=%0b", en, read_addr_o, fifo_level_o,
             fifo_read_data_o, fifo_empty_h_o);
    compare_all();
  endtask

  task automatic do_reset();
    resetn_i         = 1'b0;
    write_addr_i     = '0;
    fifo_read_en_h_i = 1'b0;
    @(posedge clk_i);
    pend.delete();
    m_valid = 1'b0; m_data = '0; m_rd = '0; m_uf = 1'b0; m_err = 1'b0;
    #1;
    resetn_i = 1'b1;
    $display("reset done");
    compare_all();
  endtask

  initial begin
    logic [AW:0] prev_addr;
    logic        saw_wrap;
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = '0;
    resetn_i = 1'b0; write_addr_i = '0; fifo_read_en_h_i = 1'b0;

    // Reset state, idle
    do_reset();
    cycle(1'b0);
    check_val("idle_level", 32'(fifo_level_o), 32'd0);

    // First word after empty appears one cycle later
    push_word(16'hA5A5);
    cycle(1'b0);
    check_val("first_data",  32'(fifo_read_data_o), 32'hA5A5);
    check_val("first_empty", 32'(fifo_empty_h_o),   32'd0);
    check_val("first_addr",  32'(read_addr_o),      32'd1);
    check_val("first_level", 32'(fifo_level_o),     32'd1);

    // Full capacity: DEPTH words at once, then one more
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_word(DW'(16'h1000 + i));
    cycle(1'b0);
    check_val("jump16_addr",  32'(read_addr_o),  32'd1);
    check_val("jump16_level", 32'(fifo_level_o), 32'd16);
    push_word(16'hBEEF);
    #1;
    check_val("cap_level", 32'(fifo_level_o), 32'd17);
    cycle(1'b0);
    check_val("cap_err", 32'(fifo_ptr_err_h_o), 32'd0);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b1);

    // Continuous pops across the pointer wrap
    do_reset();
    push_word(DW'(0)); push_word(DW'(1));
    cycle(1'b0);
    saw_wrap = 1'b0;
    for (int i = 2; i < 42; i++) begin
      prev_addr = read_addr_o;
      push_word(DW'(i));
      cycle(1'b1);
      if (prev_addr == 5'd31 && read_addr_o == 5'd0) saw_wrap = 1'b1;
    end
    check_val("stream_wrap", 32'(saw_wrap), 32'd1);

    // Pop while empty sets sticky underflow without moving the pointer
    do_reset();
    cycle(1'b1);
    check_val("uf_set",  32'(fifo_underflow_h_o), 32'd1);
    check_val("uf_addr", 32'(read_addr_o),        32'd0);
    push_word(16'h0055);
    cycle(1'b0);
    cycle(1'b1);
    check_val("uf_sticky", 32'(fifo_underflow_h_o), 32'd1);

    // Reset with 5 words held
    for (int i = 0; i < 5; i++) push_word(DW'(16'h2000 + i));
    cycle(1'b0);
    do_reset();
    check_val("rst_empty", 32'(fifo_empty_h_o),     32'd1);
    check_val("rst_addr",  32'(read_addr_o),        32'd0);
    check_val("rst_uf",    32'(fifo_underflow_h_o), 32'd0);

    // Inconsistent write pointer (18 ahead)
    write_addr_i = read_addr_o + 5'd18;
    @(posedge clk_i); #1;
    $display("ptr_err probe err=%0b", fifo_ptr_err_h_o);
    check_val("ptr_err_set", 32'(fifo_ptr_err_h_o), 32'd1);
    write_addr_i = read_addr_o;
    @(posedge clk_i); #1;
    check_val("ptr_err_sticky", 32'(fifo_ptr_err_h_o), 32'd1);

    // Randomized traffic with alternating producer/consumer bias
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int n;
      logic en;
      n  = (((i / 100) % 2) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1));
      en = (((i / 100) % 2) == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      for (int k = 0; k < n; k++) push_word(DW'($urandom));
      cycle(en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_out.md
SYNC_FIFO_OUT -- requirements
Module: sync_fifo_out

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4: memory address width; memory depth DEPTH = 2^ADDR_WIDTH.
REQ-003 clk_i  input  1: single clock for all logic.
REQ-004 resetn_i  input  1: reset, synchronous, active-low.
REQ-005 fifo_read_en_h_i  input  1: consumer pop request.
REQ-006 fifo_read_data_o  output  DATA_WIDTH: head word, registered.
REQ-007 fifo_empty_h_o  output  1: high when no head word is valid.
REQ-008 fifo_level_o  output  ADDR_WIDTH+2: words held, counting memory plus output register.
REQ-009 fifo_underflow_h_o  output  1: sticky; pop attempted while empty.
REQ-010 fifo_ptr_err_h_o  output  1: sticky; inconsistent write pointer.
REQ-011 write_addr_i  input  ADDR_WIDTH+1: write-side pointer, including wrap bit.
REQ-012 read_addr_o  output  ADDR_WIDTH+1: read pointer, registered, returned to the write side.
REQ-013 read_data_i  input  DATA_WIDTH: asynchronous memory word at read_addr_o[ADDR_WIDTH-1:0].

Function
REQ-014 The block SHALL keep a registered read pointer rd_ptr (ADDR_WIDTH+1 bits) driven directly onto read_addr_o.
REQ-015 Memory empty SHALL be mem_empty = (write_addr_i == rd_ptr), comparing all ADDR_WIDTH+1 bits.
REQ-016 The block SHALL hold a one-word output register (out_data, out_valid); fifo_read_data_o = out_data and fifo_empty_h_o = ~out_valid.
REQ-017 Pop = fifo_read_en_h_i & out_valid. Load = ~mem_empty & (~out_valid | pop).
REQ-018 On load, at the clock edge: out_data <= read_data_i, out_valid <= 1, rd_ptr <= rd_ptr + 1 modulo 2^(ADDR_WIDTH+1).
REQ-019 On pop without load, out_valid SHALL clear at the edge; out_data holds its value.
REQ-020 Simultaneous pop and load SHALL replace the head word in the same edge, so back-to-back pops sustain one word per cycle.
REQ-021 Latency: the first word after empty appears on fifo_read_data_o with fifo_empty_h_o low exactly one cycle after write_addr_i advances.
REQ-022 Behaviour is first-word-fall-through: the head word is valid before the pop; a pop consumes it.
REQ-023 A pop while empty SHALL change no state except setting fifo_underflow_h_o.
REQ-024 fifo_level_o SHALL be combinational: (write_addr_i - rd_ptr) modulo 2^(ADDR_WIDTH+1), zero-extended, plus out_valid. The maximum is DEPTH+1.
REQ-025 fifo_ptr_err_h_o SHALL set when (write_addr_i - rd_ptr) modulo 2^(ADDR_WIDTH+1) > DEPTH, and remains set until reset.
REQ-026 Pointer wrap SHALL be seamless: the wrap bit toggles on each DEPTH-boundary crossing, with no bubble.
REQ-027 Total capacity seen by the producer SHALL be DEPTH+1 words.

Reset
REQ-028 While resetn_i is low at a clock edge: rd_ptr = 0, out_valid = 0, out_data = 0, fifo_underflow_h_o = 0, fifo_ptr_err_h_o = 0.
REQ-029 Reset mid-operation SHALL discard the head word and all pending words. The write side SHALL share resetn_i; there is no partial recovery.
REQ-030 Before the first reset edge, output values are undefined. After reset: fifo_empty_h_o = 1, read_addr_o = 0, fifo_level_o = 0.

Verification
REQ-031 Reset, then write_addr_i = 0 with no reads -> fifo_empty_h_o = 1, read_addr_o = 0, fifo_level_o = 0, both error flags 0.
REQ-032 write_addr_i steps 0->1 with read_data_i = 0xA5A5 -> one cycle later fifo_read_data_o = 0xA5A5, fifo_empty_h_o = 0, read_addr_o = 1, fifo_level_o = 1.
REQ-033 ADDR_WIDTH = 4, write_addr_i jumps to 16 with no pops -> after 1 cycle, read_addr_o = 1 and fifo_level_o = 16; with write_addr_i = 17 instead -> fifo_level_o = 17, fifo_ptr_err_h_o = 0.
REQ-034 Continuous pops over 40 words spanning the 31->0 pointer wrap -> one word per cycle, in order, no empty gap, read_addr_o follows 31 -> 0.
REQ-035 Pop while empty -> fifo_underflow_h_o = 1 and stays 1; read_addr_o unchanged. Force write_addr_i - rd_ptr = 18 -> fifo_ptr_err_h_o = 1.
REQ-036 resetn_i = 0 for one cycle with 5 words held -> next cycle: fifo_empty_h_o = 1, read_addr_o = 0, both flags cleared.
